// File: rtl/branch_resolution_unit_pkg.sv
// Shared types and defaults for the branch resolution unit: FSM encoding,
// tracking-slot layout and the resolution predicate.
package branch_resolution_unit_pkg;

  localparam int PC_W             = 32;
  localparam int FLUSH_CNT_W      = 3;
  localparam int FLUSH_CYCLES_DEF = 2;
  localparam int PC_STEP_DEF      = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } bru_state_e;

  typedef struct packed {
    logic            valid;
    logic            pred;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] target;
  } bru_slot_t;

  // A not-taken outcome is correct regardless of the predicted target.
  function automatic logic bru_is_correct(input logic            pred,
                                          input logic            taken,
                                          input logic [PC_W-1:0] pred_target,
                                          input logic [PC_W-1:0] act_target);
    return (pred == taken) && (!taken || (pred_target == act_target));
  endfunction

endpackage

// File: rtl/branch_resolution_unit_sat_counter.sv
// 32-bit saturating up-counter with synchronous reset and count enable.
module bru_sat_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] count
);

  logic [31:0] count_r;

  // Count enabled events, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 32'd0;
    end else if (en && (count_r != 32'hFFFF_FFFF)) begin
      count_r <= count_r + 32'd1;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/branch_resolution_unit.sv
// Tracks conditional branches from decode through EX/MEM, resolves them in MEM
// and produces predictor-update strobes, mispredict redirect and flush.
module branch_resolution_unit
  import branch_resolution_unit_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int unsigned PC_STEP      = PC_STEP_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            dec_valid,
  input  logic            dec_prediction,
  input  logic [PC_W-1:0] dec_pc,
  input  logic [PC_W-1:0] dec_target,
  input  logic            mem_taken,
  input  logic [PC_W-1:0] mem_target,
  output logic            branch_mem_sig,
  output logic            actual_branch_decision,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic [31:0]     cnt_branches,
  output logic [31:0]     cnt_mispredicts
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [PC_W-1:0]        PC_STEP_L  = PC_W'(PC_STEP);

  bru_slot_t               ex_r, mem_r;
  bru_state_e              state_r, state_s;
  logic [FLUSH_CNT_W-1:0]  flush_cnt_r, flush_cnt_s;
  logic                    flush_r;
  logic                    branch_mem_sig_r, actual_r, mispredict_r;
  logic [PC_W-1:0]         redirect_pc_r;
  logic                    resolve_s, wrong_s;

  assign resolve_s = mem_r.valid && !stall && !flush_r;
  assign wrong_s   = resolve_s &&
                     !bru_is_correct(mem_r.pred, mem_taken, mem_r.target, mem_target);

  // EX/MEM tracking slots: advance, hold on stall, invalidate on flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_r  <= '0;
      mem_r <= '0;
    end else if (stall) begin
      ex_r  <= ex_r;
      mem_r <= mem_r;
    end else if (flush_r) begin
      ex_r.valid  <= 1'b0;
      mem_r.valid <= 1'b0;
    end else begin
      ex_r  <= '{valid: dec_valid, pred: dec_prediction, pc: dec_pc, target: dec_target};
      mem_r <= ex_r;
    end
  end

  // Flush FSM next state; the count runs down even while stalled.
  always_comb begin
    state_s     = state_r;
    flush_cnt_s = flush_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (wrong_s) begin
          state_s     = ST_FLUSH;
          flush_cnt_s = FLUSH_LOAD;
        end else begin
          state_s     = ST_IDLE;
          flush_cnt_s = {FLUSH_CNT_W{1'b0}};
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_r == {FLUSH_CNT_W{1'b0}}) begin
          state_s     = ST_IDLE;
          flush_cnt_s = {FLUSH_CNT_W{1'b0}};
        end else begin
          state_s     = ST_FLUSH;
          flush_cnt_s = flush_cnt_r - {{(FLUSH_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s     = ST_IDLE;
        flush_cnt_s = {FLUSH_CNT_W{1'b0}};
      end
    endcase
  end

  // FSM state, flush count and registered flush output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      flush_cnt_r <= {FLUSH_CNT_W{1'b0}};
      flush_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      flush_cnt_r <= flush_cnt_s;
      flush_r     <= (state_s == ST_FLUSH);
    end
  end

  // Registered resolution strobes; redirect_pc keeps its last value otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_mem_sig_r <= 1'b0;
      actual_r         <= 1'b0;
      mispredict_r     <= 1'b0;
      redirect_pc_r    <= '0;
    end else begin
      branch_mem_sig_r <= resolve_s;
      actual_r         <= resolve_s && mem_taken;
      mispredict_r     <= wrong_s;
      if (wrong_s) begin
        redirect_pc_r <= mem_taken ? mem_target : (mem_r.pc + PC_STEP_L);
      end
    end
  end

  bru_sat_counter u_cnt_branches (
    .clk   (clk),
    .reset (reset),
    .en    (resolve_s),
    .count (cnt_branches)
  );

  bru_sat_counter u_cnt_mispredicts (
    .clk   (clk),
    .reset (reset),
    .en    (wrong_s),
    .count (cnt_mispredicts)
  );

  assign branch_mem_sig         = branch_mem_sig_r;
  assign actual_branch_decision = actual_r;
  assign mispredict             = mispredict_r;
  assign redirect_pc            = redirect_pc_r;
  assign flush                  = flush_r;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Self-checking bench for branch_resolution_unit: directed table, corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_branch_resolution_unit;

  localparam int FLUSH_CYCLES = 2;
  localparam int PC_STEP      = 4;

  logic        clk;
  logic        reset, stall, dec_valid, dec_prediction, mem_taken;
  logic [31:0] dec_pc, dec_target, mem_target;
  logic        branch_mem_sig, actual_branch_decision, mispredict, flush;
  logic [31:0] redirect_pc, cnt_branches, cnt_mispredicts;

  int checks = 0;
  int failures = 0;

  branch_resolution_unit #(.FLUSH_CYCLES(FLUSH_CYCLES), .PC_STEP(PC_STEP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .dec_valid(dec_valid),
    .dec_prediction(dec_prediction), .dec_pc(dec_pc), .dec_target(dec_target),
    .mem_taken(mem_taken), .mem_target(mem_target),
    .branch_mem_sig(branch_mem_sig), .actual_branch_decision(actual_branch_decision),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .flush(flush),
    .cnt_branches(cnt_branches), .cnt_mispredicts(cnt_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: branches in flight by age, plus remaining flush cycles.
  logic        m_ex_v, m_ex_p, m_mem_v, m_mem_p;
  logic [31:0] m_ex_pc, m_ex_tg, m_mem_pc, m_mem_tg;
  int          m_flush_left;
  logic        m_strobe, m_dec, m_misp;
  logic [31:0] m_redir;
  longint      m_cb, m_cm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic resolve, wrong, was_flushing;
    if (reset) begin
      m_ex_v = 1'b0; m_mem_v = 1'b0; m_flush_left = 0;
      m_strobe = 1'b0; m_dec = 1'b0; m_misp = 1'b0; m_redir = 32'd0;
      m_cb = 0; m_cm = 0;
    end else begin
      was_flushing = (m_flush_left > 0);
      resolve = m_mem_v && !stall && !was_flushing;
      wrong = resolve && ((m_mem_p != mem_taken) || (mem_taken && (m_mem_tg != mem_target)));
      m_strobe = resolve;
      m_dec    = resolve && mem_taken;
      m_misp   = wrong;
      if (wrong) m_redir = mem_taken ? mem_target : (m_mem_pc + 32'(PC_STEP));
      if (resolve && (m_cb < 64'hFFFF_FFFF)) m_cb = m_cb + 1;
      if (wrong && (m_cm < 64'hFFFF_FFFF)) m_cm = m_cm + 1;
      if (was_flushing) m_flush_left = m_flush_left - 1;
      else if (wrong) m_flush_left = FLUSH_CYCLES;
      if (!stall) begin
        if (was_flushing) begin
          m_ex_v = 1'b0; m_mem_v = 1'b0;
        end else begin
          m_mem_v = m_ex_v; m_mem_p = m_ex_p; m_mem_pc = m_ex_pc; m_mem_tg = m_ex_tg;
          m_ex_v = dec_valid; m_ex_p = dec_prediction; m_ex_pc = dec_pc; m_ex_tg = dec_target;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("branch_mem_sig", 32'(branch_mem_sig), 32'(m_strobe));
    chk("mispredict", 32'(mispredict), 32'(m_misp));
    chk("flush", 32'(flush), 32'(m_flush_left > 0));
    chk("redirect_pc", redirect_pc, m_redir);
    chk("cnt_branches", cnt_branches, m_cb[31:0]);
    chk("cnt_mispredicts", cnt_mispredicts, m_cm[31:0]);
    if (m_strobe) chk("actual_branch_decision", 32'(actual_branch_decision), 32'(m_dec));
  endtask

  task automatic cyc(input logic dv, input logic dp, input logic [31:0] dpc, input logic [31:0] dtg,
                     input logic mt, input logic [31:0] mtg, input logic st, input logic rs);
    dec_valid = dv; dec_prediction = dp; dec_pc = dpc; dec_target = dtg;
    mem_taken = mt; mem_target = mtg; stall = st; reset = rs;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic        pred;
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic [31:0] act_target;
    logic        exp_misp;
    logic [31:0] exp_redir;
  } vec_t;

  vec_t        vecs[7];
  int          exp_cm;
  int          strobes;
  logic        r_dv, r_dp, r_mt, r_st, r_rs;
  logic [31:0] r_pc, r_tg, r_mtg, base_cb;

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0100, 32'h0000_0140, 1'b1, 32'h0000_0140, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 32'h0000_0200, 32'h0000_0240, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0204};
    vecs[2] = '{1'b1, 32'h0000_02F0, 32'h0000_0300, 1'b1, 32'h0000_0310, 1'b1, 32'h0000_0310};
    vecs[3] = '{1'b0, 32'h0000_0400, 32'h0000_0480, 1'b0, 32'h0000_0480, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0500, 32'h0000_0520, 1'b1, 32'h0000_0520, 1'b1, 32'h0000_0520};
    vecs[5] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_1000, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[6] = '{1'b0, 32'h0000_0600, 32'h0000_0700, 1'b0, 32'hDEAD_BEE0, 1'b0, 32'h0};

    // Reset state
    cyc(1'b1, 1'b1, 32'h10, 32'h20, 1'b1, 32'h20, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("reset_outputs", {branch_mem_sig, actual_branch_decision, mispredict, flush}, 32'd0);
    chk("reset_cnt", cnt_branches | cnt_mispredicts | redirect_pc, 32'd0);

    // Table: one branch per entry, resolved two cycles after decode
    exp_cm = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, vecs[i].pred, vecs[i].pc, vecs[i].target, 1'b0, 32'd0, 1'b0, 1'b0);
      idle(1);
      cyc(1'b0, 1'b0, 32'd0, 32'd0, vecs[i].taken, vecs[i].act_target, 1'b0, 1'b0);
      if (vecs[i].exp_misp) exp_cm++;
      chk("tbl_strobe", 32'(branch_mem_sig), 32'd1);
      chk("tbl_decision", 32'(actual_branch_decision), 32'(vecs[i].taken));
      chk("tbl_mispredict", 32'(mispredict), 32'(vecs[i].exp_misp));
      chk("tbl_flush", 32'(flush), 32'(vecs[i].exp_misp));
      if (vecs[i].exp_misp) chk("tbl_redirect", redirect_pc, vecs[i].exp_redir);
      chk("tbl_cnt_b", cnt_branches, 32'(i + 1));
      chk("tbl_cnt_m", cnt_mispredicts, 32'(exp_cm));
      for (int j = 0; j < 3; j++) begin
        idle(1);
        chk("tbl_flush_tail", 32'(flush), 32'(vecs[i].exp_misp && (j == 0)));
      end
    end

    // Back-to-back branches resolve in consecutive cycles
    base_cb = cnt_branches;
    cyc(1'b1, 1'b1, 32'h900, 32'h940, 1'b0, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'h910, 32'h950, 1'b0, 32'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h940, 1'b0, 1'b0);
    chk("b2b_first", {30'd0, branch_mem_sig, mispredict}, 32'd2);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("b2b_second", {30'd0, branch_mem_sig, mispredict}, 32'd2);
    chk("b2b_count", cnt_branches, base_cb + 32'd2);
    idle(2);

    // Stall with branch in MEM: strobe only after stall drops, exactly once
    cyc(1'b1, 1'b1, 32'h600, 32'h640, 1'b0, 32'd0, 1'b0, 1'b0);
    idle(1);
    strobes = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h640, 1'b1, 1'b0);
      strobes += int'(branch_mem_sig);
    end
    chk("stall_no_strobe", 32'(strobes), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h640, 1'b0, 1'b0);
      strobes += int'(branch_mem_sig);
    end
    chk("stall_one_strobe", 32'(strobes), 32'd1);

    // Mispredict with a younger branch in EX; decode during flush ignored
    cyc(1'b1, 1'b1, 32'h700, 32'h740, 1'b0, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'h710, 32'h780, 1'b0, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h720, 32'h790, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("young_misp", 32'(mispredict), 32'd1);
    chk("young_redirect", redirect_pc, 32'h704);
    strobes = 0;
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 1'b1, 32'h730 + 32'(k), 32'h7A0, 1'b1, 32'h123, 1'b0, 1'b0);
      strobes += int'(branch_mem_sig);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h123, 1'b0, 1'b0);
      strobes += int'(branch_mem_sig);
    end
    chk("young_never_resolves", 32'(strobes), 32'd0);

    // Saturation at all-ones, then reset in the middle of a flush
    force dut.u_cnt_branches.count_r = 32'hFFFF_FFFF;
    force dut.u_cnt_mispredicts.count_r = 32'hFFFF_FFFF;
    #1;
    release dut.u_cnt_branches.count_r;
    release dut.u_cnt_mispredicts.count_r;
    m_cb = 64'hFFFF_FFFF;
    m_cm = 64'hFFFF_FFFF;
    cyc(1'b1, 1'b1, 32'h800, 32'h840, 1'b0, 32'd0, 1'b0, 1'b0);
    idle(1);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("sat_misp", 32'(mispredict), 32'd1);
    chk("sat_cnt_b", cnt_branches, 32'hFFFF_FFFF);
    chk("sat_cnt_m", cnt_mispredicts, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("rst_mid_flush", 32'(flush), 32'd0);
    chk("rst_mid_flush_cnt", cnt_branches, 32'd0);
    idle(2);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      r_dv = 1'($urandom_range(0, 1));
      r_dp = 1'($urandom_range(0, 1));
      r_pc = $urandom & 32'hFFFF_FFFC;
      r_tg = $urandom & 32'hFFFF_FFFC;
      if (m_mem_v && ($urandom_range(0, 9) < 6)) begin
        r_mt = m_mem_p; r_mtg = m_mem_tg;
      end else begin
        r_mt = 1'($urandom_range(0, 1));
        r_mtg = ($urandom_range(0, 1) == 0) ? m_mem_tg : ($urandom & 32'hFFFF_FFFC);
      end
      r_st = ($urandom_range(0, 4) == 0);
      r_rs = ($urandom_range(0, 99) == 0);
      cyc(r_dv, r_dp, r_pc, r_tg, r_mt, r_mtg, r_st, r_rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolution_unit.md
BRANCH_RESOLUTION_UNIT -- requirements
Module: branch_resolution_unit

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles flush is held after a mispredict (legal range 1..7).
REQ-002 Parameter PC_STEP, default 4, fall-through increment for not-taken redirect.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  pipeline stall; holds all tracking slots.
REQ-006 dec_valid  in  1  conditional branch present in decode this cycle.
REQ-007 dec_prediction  in  1  predictor's taken/not-taken guess for the decode branch.
REQ-008 dec_pc  in  32  PC of the decode branch.
REQ-009 dec_target  in  32  predicted-taken target (pc + offset).
REQ-010 mem_taken  in  1  actual branch decision, valid while the MEM slot holds a branch.
REQ-011 mem_target  in  32  actual computed target, valid with mem_taken.
REQ-012 branch_mem_sig  out  1  one-cycle predictor-update strobe.
REQ-013 actual_branch_decision  out  1  resolved direction, valid with branch_mem_sig.
REQ-014 mispredict  out  1  one-cycle mispredict pulse.
REQ-015 redirect_pc  out  32  correct fetch PC, valid with mispredict.
REQ-016 flush  out  1  squash younger instructions.
REQ-017 cnt_branches  out  32  resolved-branch count.
REQ-018 cnt_mispredicts  out  32  mispredict count.

Function
REQ-019 Two tracking slots EX and MEM, each {valid, pred, pc, target}.
REQ-020 When stall=0 and flush=0: EX <= decode fields (valid=dec_valid); MEM <= EX.
REQ-021 When stall=1: EX and MEM hold; no resolution, no strobes, counters hold.
REQ-022 When flush=1 and stall=0: EX.valid <= 0; MEM.valid <= 0; dec_valid ignored.
REQ-023 Resolution occurs on a posedge with MEM.valid=1, stall=0, flush=0.
REQ-024 Correct iff pred==mem_taken and (mem_taken=0 or MEM.target==mem_target).
REQ-025 Registered outputs: branch_mem_sig=1 and actual_branch_decision=mem_taken in the cycle after resolution, for exactly one cycle.
REQ-026 On incorrect resolution, mispredict=1 for one cycle in the same cycle as branch_mem_sig; redirect_pc = mem_target if mem_taken, else MEM.pc + PC_STEP (modulo 2^32).
REQ-027 redirect_pc holds its last value when mispredict=0.
REQ-028 FSM states IDLE, FLUSH; IDLE -> FLUSH on incorrect resolution; FLUSH asserts flush and counts FLUSH_CYCLES cycles, then -> IDLE.
REQ-029 flush rises in the same cycle as mispredict; stall does not extend the flush count.
REQ-030 A new mispredict cannot occur in FLUSH (slots invalidated); no handling beyond REQ-022 is required.
REQ-031 cnt_branches +1 per resolution; cnt_mispredicts +1 per incorrect resolution; both saturate at 0xFFFF_FFFF.
REQ-032 Back-to-back decode branches (consecutive cycles) are tracked independently and resolve in consecutive cycles.

Reset
REQ-033 reset=1 on posedge: slots invalid, FSM IDLE, flush count 0, all outputs 0, counters 0.
REQ-034 reset dominates stall and any in-progress flush; first resolution requires a branch to enter after reset deasserts.

Structure
REQ-035 Shared package/header holds FSM state encoding, slot field widths, default FLUSH_CYCLES and PC_STEP.
REQ-036 One sub-module bru_sat_counter (32-bit saturating up-counter with sync reset and enable), instantiated twice.

Verification
REQ-037 Decode branch pc=0x100, pred=1, target=0x140; two cycles later mem_taken=1, mem_target=0x140 -> branch_mem_sig=1, decision=1, mispredict=0, cnt_branches=1.
REQ-038 pc=0x200, pred=1; at MEM mem_taken=0 -> mispredict=1, redirect_pc=0x204, flush high 2 cycles, cnt_mispredicts=1.
REQ-039 pred=1, target=0x300; actual taken, mem_target=0x310 -> mispredict=1, redirect_pc=0x310.
REQ-040 Branch in MEM with stall=1 for 3 cycles -> no strobe until stall drops; strobe then appears exactly once.
REQ-041 Mispredict, with younger branch in EX -> younger branch never resolves; dec_valid during flush ignored.
REQ-042 Preload counters at 0xFFFF_FFFF (force), resolve a mispredict -> both counters remain 0xFFFF_FFFF; reset mid-flush -> flush=0 next cycle.
